// File: rtl/riscv_pc_pkg.sv
// riscv_pc_pkg: shared fetch-PC constants, redirect source indices and next-PC select encoding
package riscv_pc_pkg;
  localparam int XLEN = 32;
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
  localparam int INC = 4;
  localparam int SRC_BRANCH = 0;
  localparam int SRC_JAL = 1;
  localparam int SRC_JALR = 2;
  localparam int SRC_TRAP = 3;
  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_NEW,
    SEL_BUF,
    SEL_PEND,
    SEL_HOLD
  } next_sel_e;
endpackage

// File: rtl/pc_redirect_unit_prio_sel.sv
// pc_prio_sel: highest-index-wins priority encoder and target mux over redirect sources
module pc_prio_sel #(
  parameter int NUM_SRC = 4,
  parameter int XLEN = 32
) (
  input  logic [NUM_SRC-1:0]      src_valid,
  input  logic [NUM_SRC*XLEN-1:0] src_target,
  output logic                    win_valid,
  output logic [XLEN-1:0]         win_target
);
  always_comb begin
    win_valid = |src_valid;
    win_target = '0;
    for (int i = 0; i < NUM_SRC; i++)
      if (src_valid[i]) win_target = src_target[i*XLEN +: XLEN];
  end
endmodule

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: fetch PC register with prioritised redirects, stall-pending buffer and misalignment reporting
module pc_redirect_unit #(
  parameter int XLEN = riscv_pc_pkg::XLEN,
  parameter int NUM_SRC = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(riscv_pc_pkg::RESET_VECTOR),
  parameter int INC = riscv_pc_pkg::INC
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    stall,
  input  logic [NUM_SRC-1:0]      src_valid,
  input  logic [NUM_SRC*XLEN-1:0] src_target,
  output logic [XLEN-1:0]         pc,
  output logic [XLEN-1:0]         pc_inc,
  output logic                    redirected,
  output logic                    pending,
  output logic                    misalign,
  output logic [XLEN-1:0]         misalign_addr
);
  import riscv_pc_pkg::*;
  logic            win_valid, win_ok, win_bad;
  logic [XLEN-1:0] win_target;
  next_sel_e       sel;
  logic [XLEN-1:0] pc_d, pc_q, buf_d, buf_q, misalign_addr_d, misalign_addr_q;
  logic            pend_d, pend_q, redir_d, redir_q, misalign_d, misalign_q;
  pc_prio_sel #(.NUM_SRC(NUM_SRC), .XLEN(XLEN)) u_sel (
    .src_valid (src_valid),
    .src_target(src_target),
    .win_valid (win_valid),
    .win_target(win_target)
  );
  assign pc_inc = pc_q + XLEN'(INC);
  // a misaligned winner is dropped entirely, so it never touches pc or the buffer
  always_comb begin
    win_ok = win_valid && win_target[1:0] == 2'b00;
    win_bad = win_valid && win_target[1:0] != 2'b00;
    sel = win_ok ? (stall ? SEL_BUF : SEL_NEW) : stall ? SEL_HOLD : pend_q ? SEL_PEND : SEL_SEQ;
    pc_d = sel == SEL_NEW ? win_target : sel == SEL_PEND ? buf_q : sel == SEL_SEQ ? pc_inc : pc_q;
    buf_d = sel == SEL_BUF ? win_target : buf_q;
    redir_d = sel == SEL_NEW || sel == SEL_PEND;
    pend_d = sel == SEL_BUF ? 1'b1 : redir_d ? 1'b0 : pend_q;
    misalign_d = win_bad;
    misalign_addr_d = win_bad ? win_target : misalign_addr_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_VECTOR;
      buf_q <= '0;
      pend_q <= 1'b0;
      redir_q <= 1'b0;
      misalign_q <= 1'b0;
      misalign_addr_q <= '0;
    end else begin
      pc_q <= pc_d;
      buf_q <= buf_d;
      pend_q <= pend_d;
      redir_q <= redir_d;
      misalign_q <= misalign_d;
      misalign_addr_q <= misalign_addr_d;
    end
  end
  assign pc = pc_q;
  assign redirected = redir_q;
  assign pending = pend_q;
  assign misalign = misalign_q;
  assign misalign_addr = misalign_addr_q;
endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb_pc_redirect_unit: directed self-checking bench for pc_redirect_unit
module tb_pc_redirect_unit;
  logic            clk = 1'b0;
  logic            rst_n;
  logic            stall;
  logic [3:0]      src_valid;
  logic [3:0][31:0] tgt;
  logic [31:0]     pc, pc_inc, misalign_addr;
  logic            redirected, pending, misalign;
  int              n_tests = 0;
  int              n_fail = 0;
  pc_redirect_unit #(.XLEN(32), .NUM_SRC(4), .RESET_VECTOR(32'h0), .INC(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .src_valid    (src_valid),
    .src_target   (tgt),
    .pc           (pc),
    .pc_inc       (pc_inc),
    .redirected   (redirected),
    .pending      (pending),
    .misalign     (misalign),
    .misalign_addr(misalign_addr)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic state(input string tag, input logic [31:0] epc, input logic er, input logic ep, input logic em);
    chk({tag, ".pc"}, pc, epc);
    chk({tag, ".redirected"}, {31'b0, redirected}, {31'b0, er});
    chk({tag, ".pending"}, {31'b0, pending}, {31'b0, ep});
    chk({tag, ".misalign"}, {31'b0, misalign}, {31'b0, em});
  endtask
  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    src_valid = 4'b0;
    tgt = '0;
    #12;
    rst_n = 1'b1;
    state("reset", 32'h0, 0, 0, 0);
    chk("reset.misalign_addr", misalign_addr, 32'h0);
    tick(); state("seq4", 32'h4, 0, 0, 0);
    tick(); state("seq8", 32'h8, 0, 0, 0);
    tick(); state("seq12", 32'hC, 0, 0, 0);
    tick(); state("seq16", 32'h10, 0, 0, 0);
    chk("pc_inc16", pc_inc, 32'h14);
    src_valid = 4'b0001; tgt[0] = 32'h100;
    tick(); state("branch", 32'h100, 1, 0, 0);
    src_valid = 4'b0;
    tick(); state("branch_next", 32'h104, 0, 0, 0);
    src_valid = 4'b1001; tgt[0] = 32'h200; tgt[3] = 32'h80;
    tick(); state("trap_wins", 32'h80, 1, 0, 0);
    src_valid = 4'b0;
    tick(); state("trap_next", 32'h84, 0, 0, 0);
    stall = 1'b1; src_valid = 4'b0010; tgt[1] = 32'h300;
    tick(); state("stall1", 32'h84, 0, 1, 0);
    src_valid = 4'b0100; tgt[2] = 32'h400;
    tick(); state("stall2", 32'h84, 0, 1, 0);
    src_valid = 4'b0;
    tick(); state("stall3", 32'h84, 0, 1, 0);
    stall = 1'b0;
    tick(); state("release", 32'h400, 1, 0, 0);
    tick(); state("release_next", 32'h404, 0, 0, 0);
    src_valid = 4'b0001; tgt[0] = 32'h202;
    tick(); state("misal", 32'h408, 0, 0, 1);
    chk("misal.addr", misalign_addr, 32'h202);
    src_valid = 4'b0;
    tick(); state("misal_next", 32'h40C, 0, 0, 0);
    chk("misal_held.addr", misalign_addr, 32'h202);
    stall = 1'b1; src_valid = 4'b0010; tgt[1] = 32'h500;
    tick(); state("buf500", 32'h40C, 0, 1, 0);
    src_valid = 4'b0001; tgt[0] = 32'h203;
    tick(); state("misal_stall", 32'h40C, 0, 1, 1);
    chk("misal_stall.addr", misalign_addr, 32'h203);
    src_valid = 4'b0; stall = 1'b0;
    tick(); state("pend_deliver", 32'h500, 1, 0, 0);
    src_valid = 4'b1000; tgt[3] = 32'hFFFF_FFF8;
    tick(); state("to_top", 32'hFFFF_FFF8, 1, 0, 0);
    src_valid = 4'b0;
    tick(); state("top", 32'hFFFF_FFFC, 0, 0, 0);
    chk("top.pc_inc", pc_inc, 32'h0);
    tick(); state("wrap", 32'h0, 0, 0, 0);
    tick(); state("wrap_next", 32'h4, 0, 0, 0);
    stall = 1'b1; src_valid = 4'b0100; tgt[2] = 32'h600;
    tick(); state("pend600", 32'h4, 0, 1, 0);
    src_valid = 4'b0;
    #2 rst_n = 1'b0;
    #1 state("async_rst", 32'h0, 0, 0, 0);
    #2 rst_n = 1'b1; stall = 1'b0;
    tick(); state("after_rst", 32'h4, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_redirect_unit.md
Name: pc_redirect_unit

Overview:
Parametrised successor to the 2-way PC-jump select. It owns the architectural fetch PC register and chooses the next PC from sequential increment or one of NUM_SRC prioritised redirect sources (branch, jal, jalr, trap). Redirects that arrive while fetch is stalled are held in a one-entry pending buffer. Misaligned targets are rejected and reported. It sits between execute/trap logic and the instruction-memory address port.

Parameters:
XLEN, 32, PC and target width in bits.
NUM_SRC, 4, number of redirect sources (1..8); the highest index has the highest priority.
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
INC, 4, sequential increment in bytes.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
stall  input  1  hold PC; the pipeline is not accepting a new fetch address.
src_valid  input  NUM_SRC  per-source redirect request, single-cycle pulse.
src_target  input  NUM_SRC*XLEN  flattened targets; source i occupies bits [i*XLEN +: XLEN].
pc  output  XLEN  current fetch PC (registered).
pc_inc  output  XLEN  pc + INC (combinational from pc).
redirected  output  1  1-cycle pulse; pc was loaded from a redirect this cycle.
pending  output  1  a redirect is buffered, waiting for stall to drop.
misalign  output  1  1-cycle pulse; the selected target had target[1:0] != 0.
misalign_addr  output  XLEN  offending target, held until the next misalign.

Behaviour:
- Reset (rst_n=0, asynchronous): pc=RESET_VECTOR, pending=0, pending buffer=0, redirected=0, misalign=0, misalign_addr=0.
- Selection, combinational: the highest-index asserted src_valid wins; the others that cycle are discarded, not queued.
- Alignment: if the winning target[1:0] != 0, the redirect is dropped. misalign pulses the next cycle and misalign_addr captures the target. pc continues sequentially or holds if stalled. The pending buffer is unchanged.
- Next-PC priority, evaluated each rising edge when out of reset:
  1. Aligned new redirect and stall=0: pc <= target; redirected=1; pending is cleared (a new redirect supersedes any buffered one).
  2. Aligned new redirect and stall=1: buffer <= target; pending <= 1; pc holds. This overwrites any older buffered target.
  3. No new redirect, pending=1, stall=0: pc <= buffer; pending <= 0; redirected=1.
  4. No redirect, pending=0, stall=0: pc <= pc + INC. The addition is modulo 2^XLEN, so 32'hFFFF_FFFC wraps to 0.
  5. stall=1, no new redirect: pc and buffer hold.
- Latency: one cycle from src_valid to the new pc when not stalled. The earliest pc update is the cycle stall deasserts.
- redirected and misalign are registered and high for exactly one cycle.
- Reset mid-stall discards the pending redirect.
- No combinational path from src_valid/stall to pc. pc_inc depends only on pc.

Decomposition:
- Shared package riscv_pc_pkg: XLEN default, RESET_VECTOR, INC, and the source index constants SRC_BRANCH=0, SRC_JAL=1, SRC_JALR=2, SRC_TRAP=3.
- One natural sub-module: pc_prio_sel, a combinational priority encoder plus target mux (NUM_SRC, XLEN) that outputs win_valid and win_target.
- The register, buffer and alignment logic stay in the top.

Test Plan:
- Reset release with no inputs -> pc sequence 0, 4, 8, 12 on consecutive cycles; redirected and pending stay 0.
- At pc=0x10, src_valid=4'b0001 with target 0x100 -> next pc=0x100, redirected=1 for one cycle, then 0x104.
- Same cycle: src_valid=4'b1001, branch target 0x200 and trap target 0x80 -> pc=0x80 (trap wins).
- stall=1 for 3 cycles, jal target 0x300 in stall cycle 1, jalr target 0x400 in stall cycle 2 -> pending=1, pc frozen; on stall release pc=0x400, redirected=1, pending=0.
- Branch target 0x202 while not stalled -> pc continues pc+4, misalign=1 for one cycle, misalign_addr=0x202; a pending buffer loaded earlier is still delivered afterwards.
- pc=0xFFFF_FFFC, no redirect -> next pc=0x0000_0000. Assert rst_n=0 while pending=1 -> pc=RESET_VECTOR immediately, pending=0.
